// File: rtl/usb_fs_in_pe.sv
// usb_fs_in_pe: USB full-speed IN protocol engine with per-endpoint packet buffers,
// DATA0/DATA1/NAK/STALL responses and retry-until-ACK toggle tracking.
module usb_fs_in_pe #(
   parameter int NUM_IN_EPS = 1,
   parameter int MAX_IN_PACKET_SIZE = 32,
   parameter int ACK_TIMEOUT = 255
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_IN_EPS-1:0] reset_ep,
   input  logic [6:0]            dev_addr,
   output logic [NUM_IN_EPS-1:0] in_ep_data_free,
   input  logic [NUM_IN_EPS-1:0] in_ep_data_put,
   input  logic [7:0]            in_ep_data,
   input  logic [NUM_IN_EPS-1:0] in_ep_data_done,
   input  logic [NUM_IN_EPS-1:0] in_ep_stall,
   output logic [NUM_IN_EPS-1:0] in_ep_acked,
   input  logic                  rx_pkt_start,
   input  logic                  rx_pkt_end,
   input  logic                  rx_pkt_valid,
   input  logic [3:0]            rx_pid,
   input  logic [6:0]            rx_addr,
   input  logic [3:0]            rx_endp,
   input  logic [10:0]           rx_frame_num,
   output logic                  tx_pkt_start,
   input  logic                  tx_pkt_end,
   output logic [3:0]            tx_pid,
   output logic                  tx_data_avail,
   input  logic                  tx_data_get,
   output logic [7:0]            tx_data
);
   localparam int EW = NUM_IN_EPS > 1 ? $clog2(NUM_IN_EPS) : 1;
   localparam int AW = MAX_IN_PACKET_SIZE > 1 ? $clog2(MAX_IN_PACKET_SIZE) : 1;
   localparam int PW = $clog2(MAX_IN_PACKET_SIZE + 1);
   localparam int TW = $clog2(ACK_TIMEOUT + 1);
   localparam logic [1:0] EP_READY = 2'd0, EP_PUT = 2'd1, EP_GET = 2'd2, EP_STALL = 2'd3;
   localparam logic [1:0] X_IDLE = 2'd0, X_RCVD = 2'd1, X_SEND = 2'd2, X_WAIT = 2'd3;

   logic [NUM_IN_EPS-1:0][1:0]    ep_st_q, ep_st_d;
   logic [NUM_IN_EPS-1:0][PW-1:0] ep_pa_q, ep_pa_d;
   logic [NUM_IN_EPS-1:0]         ep_tg_q, ep_tg_d, acked_q, acked_d, wr;
   logic [7:0]                    mem_q [NUM_IN_EPS][MAX_IN_PACKET_SIZE];
   logic [1:0]                    xfer_q, xfer_d, cur_st;
   logic [EW-1:0]                 cur_q, cur_d;
   logic [PW-1:0]                 ga_q, ga_d, len_q, len_d;
   logic [TW-1:0]                 timer_q, timer_d;
   logic [7:0]                    tx_data_q;
   logic                          tok_ok, in_tok, setup_tok, ack_tok, unused_ok;

   assign tok_ok    = rx_pkt_end && rx_pkt_valid && rx_addr == dev_addr && {1'b0, rx_endp} < 5'(NUM_IN_EPS);
   assign in_tok    = tok_ok && rx_pid == 4'b1001;
   assign setup_tok = tok_ok && rx_pid == 4'b1101;
   assign ack_tok   = xfer_q == X_WAIT && rx_pkt_end && rx_pkt_valid && rx_pid == 4'b0010;
   assign unused_ok = ^{rx_pkt_start, rx_frame_num};

   assign cur_st        = ep_st_q[cur_q];
   assign tx_pkt_start  = xfer_q == X_RCVD;
   assign tx_pid        = !tx_pkt_start ? 4'b0000 : cur_st == EP_STALL ? 4'b1110 :
                          cur_st != EP_GET ? 4'b1010 : ep_tg_q[cur_q] ? 4'b1011 : 4'b0011;
   assign tx_data_avail = xfer_q == X_SEND && ga_q < len_q;
   assign tx_data       = tx_data_q;
   assign in_ep_acked   = acked_q;

   always_comb begin
      ep_st_d = ep_st_q;
      ep_pa_d = ep_pa_q;
      ep_tg_d = ep_tg_q;
      wr = '0;
      acked_d = '0;
      in_ep_data_free = '0;
      for (int i = 0; i < NUM_IN_EPS; i++) begin
         in_ep_data_free[i] = ~ep_st_q[i][1];
         if (in_ep_stall[i]) begin
            ep_st_d[i] = EP_STALL;
            if (setup_tok && rx_endp == 4'(i)) ep_tg_d[i] = 1'b1;
         end else if (reset_ep[i]) begin
            ep_st_d[i] = EP_READY;
            ep_pa_d[i] = '0;
            ep_tg_d[i] = 1'b0;
         end else if (setup_tok && rx_endp == 4'(i)) begin
            ep_st_d[i] = EP_READY;
            ep_pa_d[i] = '0;
            ep_tg_d[i] = 1'b1;
         end else if (ep_st_q[i] == EP_GET) begin
            if (ack_tok && cur_q == EW'(i)) begin
               ep_st_d[i] = EP_READY;
               ep_pa_d[i] = '0;
               ep_tg_d[i] = ~ep_tg_q[i];
               acked_d[i] = 1'b1;
            end
         end else if (ep_st_q[i] != EP_STALL) begin
            wr[i] = in_ep_data_put[i] && ep_pa_q[i] != PW'(MAX_IN_PACKET_SIZE);
            ep_pa_d[i] = ep_pa_q[i] + PW'(wr[i]);
            ep_st_d[i] = (in_ep_data_done[i] || ep_pa_d[i] == PW'(MAX_IN_PACKET_SIZE)) ? EP_GET :
                         wr[i] ? EP_PUT : ep_st_q[i];
         end
      end
   end

   // Length is latched at response time so a flush mid-transfer cannot truncate the packet in flight.
   always_comb begin
      xfer_d = xfer_q;
      cur_d = cur_q;
      ga_d = ga_q;
      len_d = len_q;
      timer_d = timer_q;
      if (xfer_q == X_IDLE) begin
         xfer_d = in_tok ? X_RCVD : X_IDLE;
         cur_d = in_tok ? rx_endp[EW-1:0] : cur_q;
      end else if (xfer_q == X_RCVD) begin
         xfer_d = cur_st == EP_GET ? X_SEND : X_IDLE;
         ga_d = '0;
         len_d = ep_pa_q[cur_q];
      end else if (xfer_q == X_SEND) begin
         ga_d = ga_q + PW'(tx_data_get && tx_data_avail);
         xfer_d = tx_pkt_end ? X_WAIT : X_SEND;
         timer_d = '0;
      end else begin
         timer_d = timer_q + TW'(1);
         xfer_d = (rx_pkt_end || timer_q == TW'(ACK_TIMEOUT)) ? X_IDLE : X_WAIT;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ep_st_q <= '0;
         ep_pa_q <= '0;
         ep_tg_q <= '0;
         acked_q <= '0;
         xfer_q <= X_IDLE;
         cur_q <= '0;
         ga_q <= '0;
         len_q <= '0;
         timer_q <= '0;
         tx_data_q <= '0;
      end else begin
         ep_st_q <= ep_st_d;
         ep_pa_q <= ep_pa_d;
         ep_tg_q <= ep_tg_d;
         acked_q <= acked_d;
         xfer_q <= xfer_d;
         cur_q <= cur_d;
         ga_q <= ga_d;
         len_q <= len_d;
         timer_q <= timer_d;
         tx_data_q <= xfer_d == X_SEND ? mem_q[cur_d][ga_d[AW-1:0]] : 8'h00;
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_IN_EPS; i++)
         if (wr[i]) mem_q[i][ep_pa_q[i][AW-1:0]] <= in_ep_data;
   end
endmodule

// File: tb/tb_usb_fs_in_pe.sv
// tb_usb_fs_in_pe: directed scenario bench for the IN protocol engine (2 endpoints).
module tb_usb_fs_in_pe;
   localparam logic [6:0] ADDR = 7'h2A;
   localparam logic [3:0] P_IN = 4'b1001, P_SETUP = 4'b1101, P_ACK = 4'b0010;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic [1:0] reset_ep = '0, in_ep_data_put = '0, in_ep_data_done = '0, in_ep_stall = '0;
   logic [1:0] in_ep_data_free, in_ep_acked;
   logic [6:0] dev_addr = ADDR, rx_addr = '0;
   logic [7:0] in_ep_data = '0, tx_data;
   logic rx_pkt_start = 1'b0, rx_pkt_end = 1'b0, rx_pkt_valid = 1'b0;
   logic [3:0] rx_pid = '0, rx_endp = '0, tx_pid;
   logic [10:0] rx_frame_num = '0;
   logic tx_pkt_start, tx_pkt_end = 1'b0, tx_data_avail, tx_data_get = 1'b0;
   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   usb_fs_in_pe #(.NUM_IN_EPS(2), .MAX_IN_PACKET_SIZE(32), .ACK_TIMEOUT(255)) dut (
      .clk(clk), .reset(reset), .reset_ep(reset_ep), .dev_addr(dev_addr),
      .in_ep_data_free(in_ep_data_free), .in_ep_data_put(in_ep_data_put), .in_ep_data(in_ep_data),
      .in_ep_data_done(in_ep_data_done), .in_ep_stall(in_ep_stall), .in_ep_acked(in_ep_acked),
      .rx_pkt_start(rx_pkt_start), .rx_pkt_end(rx_pkt_end), .rx_pkt_valid(rx_pkt_valid),
      .rx_pid(rx_pid), .rx_addr(rx_addr), .rx_endp(rx_endp), .rx_frame_num(rx_frame_num),
      .tx_pkt_start(tx_pkt_start), .tx_pkt_end(tx_pkt_end), .tx_pid(tx_pid),
      .tx_data_avail(tx_data_avail), .tx_data_get(tx_data_get), .tx_data(tx_data));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic put(input int ep, input logic [7:0] d);
      in_ep_data_put = 2'(1 << ep);
      in_ep_data = d;
      tick();
      in_ep_data_put = '0;
   endtask

   task automatic done(input int ep);
      in_ep_data_done = 2'(1 << ep);
      tick();
      in_ep_data_done = '0;
   endtask

   task automatic token(input logic [3:0] pid, input logic [6:0] addr, input logic [3:0] endp, input logic valid);
      rx_pkt_end = 1'b1;
      rx_pkt_valid = valid;
      rx_pid = pid;
      rx_addr = addr;
      rx_endp = endp;
      tick();
      rx_pkt_end = 1'b0;
      rx_pkt_valid = 1'b0;
   endtask

   task automatic get_byte();
      tx_data_get = 1'b1;
      tick();
      tx_data_get = 1'b0;
      tick();
   endtask

   task automatic pkt_end();
      tx_pkt_end = 1'b1;
      tick();
      tx_pkt_end = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      checks++; if (in_ep_data_free !== 2'b11) begin errors++; $display("FAIL rst_free got=%b exp=11", in_ep_data_free); end
      checks++; if ({tx_pkt_start, tx_pid, tx_data_avail, tx_data, in_ep_acked} !== 16'h0) begin errors++; $display("FAIL rst_outs got=%b%b%b%h%b exp=0", tx_pkt_start, tx_pid, tx_data_avail, tx_data, in_ep_acked); end
   endtask

   task automatic test_data_toggle();
      for (int k = 0; k < 8; k++) put(1, 8'(k + 1));
      done(1);
      checks++; if (in_ep_data_free !== 2'b01) begin errors++; $display("FAIL t1_free got=%b exp=01", in_ep_data_free); end
      token(P_IN, ADDR, 4'd1, 1'b1);
      checks++; if ({tx_pkt_start, tx_pid} !== 5'b1_0011) begin errors++; $display("FAIL t1_data0 got=%b_%b exp=1_0011", tx_pkt_start, tx_pid); end
      tick();
      checks++; if (tx_pkt_start !== 1'b0) begin errors++; $display("FAIL t1_start_pulse got=%b exp=0", tx_pkt_start); end
      for (int k = 0; k < 8; k++) begin
         checks++; if ({tx_data_avail, tx_data} !== {1'b1, 8'(k + 1)}) begin errors++; $display("FAIL t1_byte%0d got=%b/%h exp=1/%h", k, tx_data_avail, tx_data, 8'(k + 1)); end
         get_byte();
      end
      checks++; if (tx_data_avail !== 1'b0) begin errors++; $display("FAIL t1_avail_end got=%b exp=0", tx_data_avail); end
      pkt_end();
      token(P_ACK, 7'd0, 4'd0, 1'b1);
      checks++; if (in_ep_acked !== 2'b10) begin errors++; $display("FAIL t1_acked got=%b exp=10", in_ep_acked); end
      tick();
      checks++; if ({in_ep_acked, in_ep_data_free} !== 4'b0011) begin errors++; $display("FAIL t1_post_ack got=%b/%b exp=00/11", in_ep_acked, in_ep_data_free); end
      put(1, 8'hAA);
      done(1);
      token(P_IN, ADDR, 4'd1, 1'b1);
      checks++; if ({tx_pkt_start, tx_pid} !== 5'b1_1011) begin errors++; $display("FAIL t1_data1 got=%b_%b exp=1_1011", tx_pkt_start, tx_pid); end
      tick();
      checks++; if (tx_data !== 8'hAA) begin errors++; $display("FAIL t1_aa got=%h exp=aa", tx_data); end
      get_byte();
      pkt_end();
      token(P_ACK, 7'd0, 4'd0, 1'b1);
      checks++; if (in_ep_acked !== 2'b10) begin errors++; $display("FAIL t1_acked2 got=%b exp=10", in_ep_acked); end
      tick();
   endtask

   task automatic test_nak_stall();
      token(P_IN, ADDR, 4'd1, 1'b1);
      checks++; if ({tx_pkt_start, tx_pid} !== 5'b1_1010) begin errors++; $display("FAIL t2_nak got=%b_%b exp=1_1010", tx_pkt_start, tx_pid); end
      tick();
      checks++; if (tx_data_avail !== 1'b0) begin errors++; $display("FAIL t2_nak_nodata got=%b exp=0", tx_data_avail); end
      in_ep_stall = 2'b01;
      tick();
      checks++; if (in_ep_data_free !== 2'b10) begin errors++; $display("FAIL t2_stall_free got=%b exp=10", in_ep_data_free); end
      token(P_IN, ADDR, 4'd0, 1'b1);
      checks++; if ({tx_pkt_start, tx_pid} !== 5'b1_1110) begin errors++; $display("FAIL t2_stall got=%b_%b exp=1_1110", tx_pkt_start, tx_pid); end
      tick();
      in_ep_stall = 2'b00;
      token(P_IN, ADDR, 4'd0, 1'b1);
      checks++; if ({tx_pkt_start, tx_pid} !== 5'b1_1110) begin errors++; $display("FAIL t2_stall_held got=%b_%b exp=1_1110", tx_pkt_start, tx_pid); end
      tick();
      token(P_SETUP, ADDR, 4'd0, 1'b1);
      checks++; if ({tx_pkt_start, in_ep_data_free} !== 3'b0_11) begin errors++; $display("FAIL t2_setup got=%b_%b exp=0_11", tx_pkt_start, in_ep_data_free); end
      put(0, 8'h55);
      done(0);
      token(P_IN, ADDR, 4'd0, 1'b1);
      checks++; if (tx_pid !== 4'b1011) begin errors++; $display("FAIL t2_setup_toggle got=%b exp=1011", tx_pid); end
      tick();
      checks++; if (tx_data !== 8'h55) begin errors++; $display("FAIL t2_byte got=%h exp=55", tx_data); end
      get_byte();
      pkt_end();
      token(P_ACK, 7'd0, 4'd0, 1'b1);
      checks++; if (in_ep_acked !== 2'b01) begin errors++; $display("FAIL t2_acked got=%b exp=01", in_ep_acked); end
      tick();
   endtask

   task automatic test_timeout();
      logic ack_seen;
      for (int k = 0; k < 3; k++) put(1, 8'(8'h11 * (k + 1)));
      done(1);
      for (int r = 0; r < 2; r++) begin
         token(P_IN, ADDR, 4'd1, 1'b1);
         checks++; if ({tx_pkt_start, tx_pid} !== 5'b1_0011) begin errors++; $display("FAIL t3_pid_try%0d got=%b_%b exp=1_0011", r, tx_pkt_start, tx_pid); end
         tick();
         for (int k = 0; k < 3; k++) begin
            checks++; if ({tx_data_avail, tx_data} !== {1'b1, 8'(8'h11 * (k + 1))}) begin errors++; $display("FAIL t3_byte%0d_try%0d got=%b/%h exp=1/%h", k, r, tx_data_avail, tx_data, 8'(8'h11 * (k + 1))); end
            get_byte();
         end
         pkt_end();
         if (r == 0) begin
            ack_seen = 1'b0;
            repeat (260) begin
               tick();
               if (in_ep_acked !== 2'b00) ack_seen = 1'b1;
            end
            checks++; if (ack_seen !== 1'b0) begin errors++; $display("FAIL t3_timeout_ack got=%b exp=0", ack_seen); end
         end
      end
      token(P_ACK, 7'd0, 4'd0, 1'b1);
      checks++; if (in_ep_acked !== 2'b10) begin errors++; $display("FAIL t3_acked got=%b exp=10", in_ep_acked); end
      tick();
   endtask

   task automatic test_zero_len_full();
      done(0);
      token(P_IN, ADDR, 4'd0, 1'b1);
      checks++; if (tx_pid !== 4'b0011) begin errors++; $display("FAIL t4_zlp_pid got=%b exp=0011", tx_pid); end
      tick();
      checks++; if (tx_data_avail !== 1'b0) begin errors++; $display("FAIL t4_zlp_avail got=%b exp=0", tx_data_avail); end
      tick();
      checks++; if (tx_data_avail !== 1'b0) begin errors++; $display("FAIL t4_zlp_avail2 got=%b exp=0", tx_data_avail); end
      pkt_end();
      token(P_ACK, 7'd0, 4'd0, 1'b1);
      checks++; if (in_ep_acked !== 2'b01) begin errors++; $display("FAIL t4_zlp_acked got=%b exp=01", in_ep_acked); end
      tick();
      for (int k = 0; k < 31; k++) put(0, 8'(k + 8'h40));
      checks++; if (in_ep_data_free !== 2'b11) begin errors++; $display("FAIL t4_free31 got=%b exp=11", in_ep_data_free); end
      put(0, 8'h5F);
      checks++; if (in_ep_data_free !== 2'b10) begin errors++; $display("FAIL t4_free32 got=%b exp=10", in_ep_data_free); end
      put(0, 8'hFF);
      checks++; if (in_ep_data_free !== 2'b10) begin errors++; $display("FAIL t4_free33 got=%b exp=10", in_ep_data_free); end
      token(P_IN, ADDR, 4'd0, 1'b1);
      checks++; if (tx_pid !== 4'b1011) begin errors++; $display("FAIL t4_full_pid got=%b exp=1011", tx_pid); end
      tick();
      for (int k = 0; k < 32; k++) begin
         checks++; if ({tx_data_avail, tx_data} !== {1'b1, 8'(k + 8'h40)}) begin errors++; $display("FAIL t4_byte%0d got=%b/%h exp=1/%h", k, tx_data_avail, tx_data, 8'(k + 8'h40)); end
         get_byte();
      end
      checks++; if (tx_data_avail !== 1'b0) begin errors++; $display("FAIL t4_avail_end got=%b exp=0", tx_data_avail); end
      pkt_end();
      token(P_ACK, 7'd0, 4'd0, 1'b1);
      checks++; if (in_ep_acked !== 2'b01) begin errors++; $display("FAIL t4_acked got=%b exp=01", in_ep_acked); end
      tick();
   endtask

   task automatic test_reset_ep();
      put(0, 8'h99);
      done(0);
      token(P_IN, ADDR, 4'd0, 1'b1);
      tick();
      pkt_end();
      token(P_ACK, 7'd0, 4'd0, 1'b1);
      tick();
      put(0, 8'h77);
      done(0);
      checks++; if (in_ep_data_free !== 2'b10) begin errors++; $display("FAIL t5_getting got=%b exp=10", in_ep_data_free); end
      reset_ep = 2'b01;
      tick();
      reset_ep = 2'b00;
      checks++; if (in_ep_data_free !== 2'b11) begin errors++; $display("FAIL t5_flush_free got=%b exp=11", in_ep_data_free); end
      token(P_IN, ADDR, 4'd0, 1'b1);
      checks++; if (tx_pid !== 4'b1010) begin errors++; $display("FAIL t5_nak got=%b exp=1010", tx_pid); end
      tick();
      put(0, 8'h66);
      done(0);
      token(P_IN, ADDR, 4'd0, 1'b1);
      checks++; if (tx_pid !== 4'b0011) begin errors++; $display("FAIL t5_toggle_clr got=%b exp=0011", tx_pid); end
      tick();
      checks++; if ({tx_data_avail, tx_data} !== 9'h166) begin errors++; $display("FAIL t5_byte got=%b/%h exp=1/66", tx_data_avail, tx_data); end
      get_byte();
      pkt_end();
      reset_ep = 2'b01;
      tick();
      reset_ep = 2'b00;
      token(P_ACK, 7'd0, 4'd0, 1'b1);
      checks++; if (in_ep_acked !== 2'b00) begin errors++; $display("FAIL t5_late_ack got=%b exp=00", in_ep_acked); end
      tick();
      token(P_IN, ADDR, 4'd0, 1'b1);
      checks++; if ({tx_pkt_start, tx_pid} !== 5'b1_1010) begin errors++; $display("FAIL t5_nak2 got=%b_%b exp=1_1010", tx_pkt_start, tx_pid); end
      tick();
   endtask

   task automatic test_bad_tokens();
      token(P_IN, ADDR ^ 7'h01, 4'd0, 1'b1);
      checks++; if (tx_pkt_start !== 1'b0) begin errors++; $display("FAIL t6_bad_addr got=%b exp=0", tx_pkt_start); end
      token(P_IN, ADDR, 4'd2, 1'b1);
      checks++; if (tx_pkt_start !== 1'b0) begin errors++; $display("FAIL t6_bad_endp got=%b exp=0", tx_pkt_start); end
      in_ep_data_put = 2'b10;
      in_ep_data_done = 2'b10;
      in_ep_data = 8'hC3;
      tick();
      in_ep_data_put = '0;
      in_ep_data_done = '0;
      for (int r = 0; r < 2; r++) begin
         token(P_IN, ADDR, 4'd1, 1'b1);
         checks++; if ({tx_pkt_start, tx_pid} !== 5'b1_1011) begin errors++; $display("FAIL t6_pid_try%0d got=%b_%b exp=1_1011", r, tx_pkt_start, tx_pid); end
         tick();
         checks++; if ({tx_data_avail, tx_data} !== 9'h1C3) begin errors++; $display("FAIL t6_byte_try%0d got=%b/%h exp=1/c3", r, tx_data_avail, tx_data); end
         get_byte();
         checks++; if (tx_data_avail !== 1'b0) begin errors++; $display("FAIL t6_len1_try%0d got=%b exp=0", r, tx_data_avail); end
         pkt_end();
         token(P_ACK, 7'd0, 4'd0, r == 1);
         checks++; if (in_ep_acked !== (r == 1 ? 2'b10 : 2'b00)) begin errors++; $display("FAIL t6_ack_try%0d got=%b exp=%b", r, in_ep_acked, (r == 1 ? 2'b10 : 2'b00)); end
         tick();
      end
   endtask

   task automatic test_mid_reset();
      put(1, 8'h3C);
      done(1);
      token(P_IN, ADDR, 4'd1, 1'b1);
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++; if ({in_ep_data_free, tx_pkt_start, tx_data_avail, tx_data} !== 12'hC00) begin errors++; $display("FAIL t7_reset got=%b/%b/%b/%h exp=11/0/0/00", in_ep_data_free, tx_pkt_start, tx_data_avail, tx_data); end
      token(P_IN, ADDR, 4'd1, 1'b1);
      checks++; if ({tx_pkt_start, tx_pid} !== 5'b1_1010) begin errors++; $display("FAIL t7_nak got=%b_%b exp=1_1010", tx_pkt_start, tx_pid); end
      tick();
   endtask

   initial begin
      test_reset();
      test_data_toggle();
      test_nak_stall();
      test_timeout();
      test_zero_len_full();
      test_reset_ep();
      test_bad_tokens();
      test_mid_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end
endmodule
